// File: rtl/qoa_pkg.sv
// Shared constants, error codes and FSM state type for the QOA stream sequencer.
package qoa_pkg;

  localparam int unsigned SLICE_LEN         = 20;
  localparam int unsigned MAX_FRAME_SAMPLES = 5120;

  localparam logic [31:0] QOA_MAGIC = 32'h716F6166;  // "qoaf"

  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_CHAN  = 2'd2;
  localparam logic [1:0] ERR_COUNT = 2'd3;

  typedef enum logic [2:0] {
    StFileHdr   = 3'd0,
    StFrameHdr  = 3'd1,
    StLmsHist   = 3'd2,
    StLmsWeight = 3'd3,
    StSlice     = 3'd4,
    StDone      = 3'd5,
    StError     = 3'd6
  } qoa_state_e;

  // Expected file-header magic byte at position idx (0..3), first byte first.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    unique case (idx)
      2'd0:    return QOA_MAGIC[31:24];
      2'd1:    return QOA_MAGIC[23:16];
      2'd2:    return QOA_MAGIC[15:8];
      default: return QOA_MAGIC[7:0];
    endcase
  endfunction

endpackage

// File: rtl/qoa_stream_sequencer_if.sv
// Byte-in / command-out bundle of the QOA stream sequencer.
// master drives bytes and observes commands; slave is the sequencer.
interface qoa_stream_sequencer_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        lms_we;
  logic        lms_sel;
  logic [1:0]  lms_idx;
  logic [15:0] lms_word;
  logic        slice_valid;
  logic [63:0] slice_word;
  logic [4:0]  slice_samples;
  logic        frame_start;
  logic        frame_end;
  logic [23:0] samplerate;
  logic [15:0] frame_samples;
  logic [2:0]  state_o;
  logic        error;
  logic [1:0]  err_code;
  logic        done;

  modport master (
    output byte_valid, byte_data,
    input  lms_we, lms_sel, lms_idx, lms_word, slice_valid, slice_word, slice_samples,
    input  frame_start, frame_end, samplerate, frame_samples, state_o, error, err_code, done
  );

  modport slave (
    input  byte_valid, byte_data,
    output lms_we, lms_sel, lms_idx, lms_word, slice_valid, slice_word, slice_samples,
    output frame_start, frame_end, samplerate, frame_samples, state_o, error, err_code, done
  );
endinterface

// File: rtl/qoa_field_assembler.sv
// Collects bytes into 8-byte fields. The 16/64-bit views include the byte
// currently on the bus, so the FSM can register a result on the completing byte.
module qoa_field_assembler (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_field_done,
  output logic [2:0]  o_byte_idx,
  output logic [15:0] o_word16,
  output logic [63:0] o_word64
);

  // Only the seven earlier bytes need storage; the eighth comes from the bus.
  logic [55:0] r_shift;
  logic [2:0]  r_cnt;

  // Shift in each consumed byte and advance the field position (wraps 7 -> 0).
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_valid) begin
      r_shift <= {r_shift[47:0], i_byte_data};
      r_cnt   <= r_cnt + 3'd1;
    end
  end

  assign o_byte_idx   = r_cnt;
  assign o_field_done = i_byte_valid && (r_cnt == 3'd7);
  assign o_word16     = {r_shift[7:0], i_byte_data};
  assign o_word64     = {r_shift, i_byte_data};

endmodule

// File: rtl/qoa_stream_sequencer.sv
// QOA byte-stream parser: validates headers, issues LMS and slice commands,
// and tracks frame/file sample budgets to flag frame and file boundaries.
module qoa_stream_sequencer
  import qoa_pkg::*;
(
  input logic             sclk,
  input logic             rst_n,
  qoa_stream_sequencer_if.slave bus
);

  qoa_state_e  r_state;
  logic        r_lms_we, r_lms_sel, r_slice_valid, r_frame_start, r_frame_end;
  logic [1:0]  r_lms_idx, r_err_code;
  logic [15:0] r_lms_word, r_frame_samples, r_frame_remaining;
  logic [63:0] r_slice_word;
  logic [4:0]  r_slice_samples;
  logic [23:0] r_samplerate;
  logic [31:0] r_file_remaining;
  logic        r_streaming, r_error, r_done;

  logic        w_consume, w_field_done, w_count_bad, w_last_slice;
  logic [2:0]  w_idx;
  logic [15:0] w_word16, w_fs;
  logic [63:0] w_word64;
  logic [4:0]  w_slice_n;
  logic [31:0] w_file_next;

  // Bytes are ignored once the stream has finished or failed.
  assign w_consume = bus.byte_valid && (r_state != StDone) && (r_state != StError);

  qoa_field_assembler u_asm (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .i_byte_valid (w_consume),
    .i_byte_data  (bus.byte_data),
    .o_field_done (w_field_done),
    .o_byte_idx   (w_idx),
    .o_word16     (w_word16),
    .o_word64     (w_word64)
  );

  // Sample-count arithmetic for the header check and the current slice.
  always_comb begin
    w_fs         = w_word64[31:16];
    w_count_bad  = (w_fs == 16'd0) || (w_fs > 16'(MAX_FRAME_SAMPLES)) ||
                   (!r_streaming && ({16'd0, w_fs} > r_file_remaining));
    w_last_slice = (r_frame_remaining <= 16'(SLICE_LEN));
    w_slice_n    = w_last_slice ? r_frame_remaining[4:0] : 5'(SLICE_LEN);
    w_file_next  = r_file_remaining - {27'd0, w_slice_n};
  end

  // Sequencer FSM with registered command pulses and status.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      r_state           <= StFileHdr;
      r_lms_we          <= 1'b0;
      r_lms_sel         <= 1'b0;
      r_lms_idx         <= '0;
      r_lms_word        <= '0;
      r_slice_valid     <= 1'b0;
      r_slice_word      <= '0;
      r_slice_samples   <= '0;
      r_frame_start     <= 1'b0;
      r_frame_end       <= 1'b0;
      r_samplerate      <= '0;
      r_frame_samples   <= '0;
      r_frame_remaining <= '0;
      r_file_remaining  <= '0;
      r_streaming       <= 1'b0;
      r_error           <= 1'b0;
      r_err_code        <= '0;
      r_done            <= 1'b0;
    end else begin
      r_lms_we      <= 1'b0;
      r_slice_valid <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      if (w_consume) begin
        unique case (r_state)
          StFileHdr: begin
            if (!w_idx[2] && (bus.byte_data != magic_byte(w_idx[1:0]))) begin
              r_state    <= StError;
              r_error    <= 1'b1;
              r_err_code <= ERR_MAGIC;
            end else if (w_field_done) begin
              r_file_remaining <= w_word64[31:0];
              r_streaming      <= (w_word64[31:0] == 32'd0);
              r_state          <= StFrameHdr;
            end
          end
          StFrameHdr: begin
            if ((w_idx == 3'd0) && (bus.byte_data != 8'd1)) begin
              r_state    <= StError;
              r_error    <= 1'b1;
              r_err_code <= ERR_CHAN;
            end else if (w_field_done) begin
              if (w_count_bad) begin
                r_state    <= StError;
                r_error    <= 1'b1;
                r_err_code <= ERR_COUNT;
              end else begin
                r_frame_start     <= 1'b1;
                r_samplerate      <= w_word64[55:32];
                r_frame_samples   <= w_fs;
                r_frame_remaining <= w_fs;
                r_state           <= StLmsHist;
              end
            end
          end
          StLmsHist, StLmsWeight: begin
            // Every second byte completes one big-endian 16-bit word.
            if (w_idx[0]) begin
              r_lms_we   <= 1'b1;
              r_lms_sel  <= (r_state == StLmsWeight);
              r_lms_idx  <= w_idx[2:1];
              r_lms_word <= w_word16;
            end
            if (w_field_done) r_state <= (r_state == StLmsHist) ? StLmsWeight : StSlice;
          end
          StSlice: begin
            if (w_field_done) begin
              r_slice_valid     <= 1'b1;
              r_slice_word      <= w_word64;
              r_slice_samples   <= w_slice_n;
              r_frame_remaining <= r_frame_remaining - {11'd0, w_slice_n};
              if (!r_streaming) r_file_remaining <= w_file_next;
              if (w_last_slice) begin
                r_frame_end <= 1'b1;
                if (!r_streaming && (w_file_next == 32'd0)) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= StFrameHdr;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.lms_we        = r_lms_we;
  assign bus.lms_sel       = r_lms_sel;
  assign bus.lms_idx       = r_lms_idx;
  assign bus.lms_word      = r_lms_word;
  assign bus.slice_valid   = r_slice_valid;
  assign bus.slice_word    = r_slice_word;
  assign bus.slice_samples = r_slice_samples;
  assign bus.frame_start   = r_frame_start;
  assign bus.frame_end     = r_frame_end;
  assign bus.samplerate    = r_samplerate;
  assign bus.frame_samples = r_frame_samples;
  assign bus.state_o       = r_state;
  assign bus.error         = r_error;
  assign bus.err_code      = r_err_code;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_qoa_stream_sequencer.sv
// Scoreboard bench: stimulus pushes expected commands, a negedge monitor pops and compares.
module tb_qoa_stream_sequencer;
  import qoa_pkg::*;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;

  qoa_stream_sequencer_if bus ();

  qoa_stream_sequencer dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [1:0]  kind;  // 0 frame_start, 1 lms, 2 slice
    logic        sel;
    logic [1:0]  idx;
    logic [15:0] w16;
    logic [63:0] w64;
    logic [4:0]  n;
    logic        fend;
    logic [23:0] rate;
    logic [15:0] fs;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  n_pulses = 0;
  int  n_frame_end = 0;

  logic [15:0] hist [4];
  logic [15:0] wts  [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every command pulse must match the head of the expectation queue.
  initial begin
    ev_t a, e;
    forever begin
      @(negedge sclk);
      if (bus.frame_start || bus.lms_we || bus.slice_valid || bus.frame_end) begin
        n_pulses++;
        if (bus.frame_end) n_frame_end++;
        a = '0;
        a.fend = bus.frame_end;
        if (bus.frame_start) begin
          a.kind = 2'd0; a.rate = bus.samplerate; a.fs = bus.frame_samples;
        end else if (bus.lms_we) begin
          a.kind = 2'd1; a.sel = bus.lms_sel; a.idx = bus.lms_idx; a.w16 = bus.lms_word;
        end else if (bus.slice_valid) begin
          a.kind = 2'd2; a.w64 = bus.slice_word; a.n = bus.slice_samples;
        end else begin
          a.kind = 2'd3;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got %h, expected no pulse", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_err++;
            $display("FAIL cmd_kind%0d: got %h, expected %h", e.kind, a, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge sclk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) @(negedge sclk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic send_file_hdr(input logic [31:0] total);
    send(8'h71); send(8'h6F); send(8'h61); send(8'h66);
    for (int i = 3; i >= 0; i--) send(total[8*i +: 8]);
  endtask

  task automatic send_frame_hdr(input logic [7:0] ch, input logic [23:0] rate,
                                input logic [15:0] fs, input bit ok);
    ev_t e;
    if (ok) begin
      e = '0; e.kind = 2'd0; e.rate = rate; e.fs = fs;
      exp_q.push_back(e);
    end
    send(ch); send(rate[23:16]); send(rate[15:8]); send(rate[7:0]);
    send(fs[15:8]); send(fs[7:0]); send(8'hAB); send(8'hCD);
  endtask

  task automatic send_lms();
    ev_t e;
    logic [15:0] w;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        w = (s == 0) ? hist[i] : wts[i];
        e = '0; e.kind = 2'd1; e.sel = (s == 1); e.idx = 2'(i); e.w16 = w;
        exp_q.push_back(e);
        send(w[15:8]); send(w[7:0]);
      end
    end
  endtask

  task automatic send_slices(input int fs);
    ev_t e;
    logic [63:0] w;
    int rem = fs;
    int k = 0;
    while (rem > 0) begin
      w = 64'h0123_4567_89AB_CDEF ^ {8{8'(k)}};
      e = '0; e.kind = 2'd2; e.w64 = w;
      e.n = (rem > 20) ? 5'd20 : 5'(rem);
      e.fend = (rem <= 20);
      exp_q.push_back(e);
      for (int b = 7; b >= 0; b--) send(w[8*b +: 8]);
      rem -= int'(e.n);
      k++;
    end
  endtask

  task automatic check_status(input string name, input logic err, input logic [1:0] code,
                              input logic dn, input qoa_state_e st);
    check(name, {bus.error, bus.err_code, bus.done, bus.state_o}, {err, code, dn, st});
  endtask

  initial begin
    int p0, fe0;
    hist = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    wts  = '{16'h0102, 16'hFEDC, 16'h8000, 16'h7FFF};
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    do_reset();

    // Reset state
    check("rst_pulses", {bus.lms_we, bus.slice_valid, bus.frame_start, bus.frame_end}, '0);
    check("rst_data", {bus.slice_word, bus.lms_word, bus.samplerate, bus.frame_samples,
                       bus.slice_samples, bus.lms_sel, bus.lms_idx}, '0);
    check_status("rst_status", 1'b0, 2'd0, 1'b0, StFileHdr);

    // Bad magic on the third byte; later bytes are ignored
    send(8'h71); send(8'h6F); send(8'h62);
    idle(2);
    check_status("bad_magic", 1'b1, ERR_MAGIC, 1'b0, StError);
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) send(8'h01);
    idle(2);
    check("bad_magic_silent", 128'(n_pulses - p0), 128'd0);
    check_status("bad_magic_sticky", 1'b1, ERR_MAGIC, 1'b0, StError);

    // Single 40-sample frame
    do_reset();
    send_file_hdr(32'd40);
    send_frame_hdr(8'd1, 24'h00AC44, 16'd40, 1'b1);
    send_lms();
    fe0 = n_frame_end;
    send_slices(40);
    idle(3);
    check("f40_drained", 128'(exp_q.size()), 128'd0);
    check("f40_frame_end", 128'(n_frame_end - fe0), 128'd1);
    check_status("f40_done", 1'b0, 2'd0, 1'b1, StDone);
    p0 = n_pulses;
    for (int i = 0; i < 8; i++) send(8'h55);
    idle(2);
    check("done_silent", 128'(n_pulses - p0), 128'd0);

    // Partial last slice: 20, 20, 5
    do_reset();
    send_file_hdr(32'd45);
    send_frame_hdr(8'd1, 24'h00BB80, 16'd45, 1'b1);
    send_lms();
    send_slices(45);
    idle(3);
    check("f45_drained", 128'(exp_q.size()), 128'd0);
    check_status("f45_done", 1'b0, 2'd0, 1'b1, StDone);

    // Channels = 2
    do_reset();
    send_file_hdr(32'd100);
    send(8'd2);
    idle(2);
    check_status("chan2", 1'b1, ERR_CHAN, 1'b0, StError);
    p0 = n_pulses;
    for (int i = 0; i < 7; i++) send(8'h00);
    idle(2);
    check("chan2_silent", 128'(n_pulses - p0), 128'd0);

    // frame_samples above the legal maximum
    do_reset();
    send_file_hdr(32'd10000);
    send_frame_hdr(8'd1, 24'h00AC44, 16'd5121, 1'b0);
    idle(2);
    check_status("fs_5121", 1'b1, ERR_COUNT, 1'b0, StError);

    // Largest legal frame_samples is accepted
    do_reset();
    send_file_hdr(32'd10000);
    send_frame_hdr(8'd1, 24'h00AC44, 16'd5120, 1'b1);
    idle(2);
    check_status("fs_5120", 1'b0, 2'd0, 1'b0, StLmsHist);

    // frame larger than remaining file samples
    do_reset();
    send_file_hdr(32'd20);
    send_frame_hdr(8'd1, 24'h00AC44, 16'd40, 1'b0);
    idle(2);
    check_status("fs_gt_file", 1'b1, ERR_COUNT, 1'b0, StError);

    // fs = 0
    do_reset();
    send_file_hdr(32'd0);
    send_frame_hdr(8'd1, 24'h00AC44, 16'd0, 1'b0);
    idle(2);
    check_status("fs_zero", 1'b1, ERR_COUNT, 1'b0, StError);

    // Streaming mode: two 20-sample frames, never done
    do_reset();
    send_file_hdr(32'd0);
    fe0 = n_frame_end;
    for (int f = 0; f < 2; f++) begin
      send_frame_hdr(8'd1, 24'h003E80, 16'd20, 1'b1);
      send_lms();
      send_slices(20);
    end
    idle(3);
    check("stream_frame_end", 128'(n_frame_end - fe0), 128'd2);
    check("stream_drained", 128'(exp_q.size()), 128'd0);
    check_status("stream_state", 1'b0, 2'd0, 1'b0, StFrameHdr);

    // Reset after three slice bytes, then a fresh stream
    do_reset();
    send_file_hdr(32'd40);
    send_frame_hdr(8'd1, 24'h00AC44, 16'd40, 1'b1);
    send_lms();
    send(8'hDE); send(8'hAD); send(8'hBE);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    check("midrst_pulses", {bus.lms_we, bus.slice_valid, bus.frame_start, bus.frame_end}, '0);
    check("midrst_data", {bus.slice_word, bus.lms_word, bus.samplerate, bus.frame_samples,
                          bus.slice_samples, bus.lms_sel, bus.lms_idx}, '0);
    check_status("midrst_status", 1'b0, 2'd0, 1'b0, StFileHdr);
    rst_n = 1'b1;
    check("midrst_q_drained", 128'(exp_q.size()), 128'd0);
    send_file_hdr(32'd25);
    send_frame_hdr(8'd1, 24'h001F40, 16'd25, 1'b1);
    send_lms();
    send_slices(25);
    idle(3);
    check("fresh_drained", 128'(exp_q.size()), 128'd0);
    check_status("fresh_done", 1'b0, 2'd0, 1'b1, StDone);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qoa_stream_sequencer.md
Name: qoa_stream_sequencer

Overview:
Parses the incoming QOA byte stream in the SPI clock domain and sequences the decoder datapath. It checks the file header, extracts frame-header fields and per-frame LMS state, then emits 16-bit LMS words and 64-bit slices as one-cycle commands. It counts slice samples against the frame and file totals to mark frame and file boundaries. It sits between the SPI byte deserializer and the clock-domain crossing into the decoder.

Parameters:
SLICE_LEN, 20, samples per full slice
MAX_FRAME_SAMPLES, 5120, largest legal frame_samples (256 slices)

Ports:
sclk  in  1  SPI clock; all logic is clocked on the posedge
rst_n  in  1  synchronous, active-low reset, sampled on sclk
byte_valid  in  1  one-cycle pulse; a complete received byte is on byte_data
byte_data  in  8  received byte, MSB-first order already resolved
lms_we  out  1  one-cycle pulse; lms_word is valid
lms_sel  out  1  0 = history, 1 = weight
lms_idx  out  2  history/weight index 0..3
lms_word  out  16  signed big-endian word
slice_valid  out  1  one-cycle pulse; slice_word is valid
slice_word  out  64  slice, first byte in [63:56]
slice_samples  out  5  valid samples in this slice, 1..20
frame_start  out  1  pulse when the frame header is accepted
frame_end  out  1  pulse coincident with the last slice_valid of a frame
samplerate  out  24  latched from the frame header
frame_samples  out  16  latched from the frame header
state_o  out  3  current FSM state
error  out  1  sticky error flag
err_code  out  2  1 = bad magic, 2 = channels != 1, 3 = bad sample count
done  out  1  sticky; all file samples have been sequenced

Behaviour:
- Reset: every output is 0 and the FSM is in FILE_HDR. All internal counters, the 64-bit shift register and file_remaining are cleared.
- A byte is consumed only on a byte_valid cycle. Each byte shifts into a 64-bit register and increments a field byte counter (0..7).
- Output latency: every pulse output and its data are registered. They assert on the cycle after the byte_valid that completes the field.
- FSM states: FILE_HDR, FRAME_HDR, LMS_HIST, LMS_WEIGHT, SLICE, DONE, ERROR.
- FILE_HDR (8 bytes):
  - Bytes 0..3 must be 0x71 0x6F 0x61 0x66. Any mismatch goes to ERROR with code 1, decided on the mismatching byte.
  - Bytes 4..7 form the big-endian u32 file_total, loaded into file_remaining.
  - file_total = 0 means streaming mode: DONE is never reached.
  - Next state is FRAME_HDR.
- FRAME_HDR (8 bytes):
  - Byte 0 is channels. Any value other than 1 goes to ERROR with code 2.
  - Bytes 1..3 are samplerate, bytes 4..5 are frame_samples, bytes 6..7 are frame size and are ignored.
  - After byte 7, check the sample count. It is bad (ERROR, code 3) if fs = 0, if fs > MAX_FRAME_SAMPLES, or if fs > file_remaining when not streaming.
  - Otherwise: pulse frame_start, latch samplerate and frame_samples, set frame_remaining = fs, and go to LMS_HIST.
- LMS_HIST and LMS_WEIGHT (8 bytes each):
  - Each byte pair produces one lms_we pulse, idx 0..3. lms_sel is 0 in LMS_HIST and 1 in LMS_WEIGHT.
  - LMS_HIST goes to LMS_WEIGHT; LMS_WEIGHT goes to SLICE.
- SLICE (8 bytes per slice):
  - On the 8th byte, pulse slice_valid. slice_samples = min(frame_remaining, 20).
  - Subtract slice_samples from frame_remaining, and from file_remaining when not streaming.
  - If frame_remaining was <= 20: pulse frame_end in the same cycle.
  - At frame end, go to DONE if not streaming and the new file_remaining = 0; otherwise go to FRAME_HDR.
- DONE: set done = 1; byte_valid is ignored.
- ERROR: set error = 1 and latch err_code. No further command pulses are issued; byte_valid is ignored. The only exit is reset.
- Field counter: wraps 7 -> 0 at every field boundary. Partial fields are never emitted.
- Reset mid-field: the partial field is discarded. The next byte is treated as file byte 0.
- byte_valid on consecutive sclk cycles is legal; each one is consumed.

Decomposition:
- Package qoa_pkg holds:
  - the state enum;
  - the QOA_MAGIC constant 32'h716F6166;
  - SLICE_LEN and MAX_FRAME_SAMPLES;
  - the err_code constants (ERR_MAGIC, ERR_CHAN, ERR_COUNT).
- One sub-module, qoa_field_assembler: the 64-bit shift register plus the 3-bit field byte counter. It outputs field_done, byte_idx, and the assembled 16-bit and 64-bit views.
- The sequencer FSM and the sample arithmetic remain in qoa_stream_sequencer.

Test Plan:
- Bad magic: send 71 6F 62 → error=1, err_code=1, state_o=ERROR. A further 8 bytes produce no slice_valid or lms_we.
- Single frame, 40 samples:
  - Send file_total=40, frame channels=1, rate 44100 (0x00AC44), fs=40.
  - Expect frame_start, then 4 history and 4 weight lms_we pulses with the words in send order (e.g. 0x1234 at idx0).
  - Expect 2 slice_valid pulses with slice_samples=20 and 20. frame_end comes with the 2nd pulse, then done=1.
- Partial last slice: fs=45 → slice_samples 20, 20, 5. frame_end comes with the 3rd slice_valid.
- Channels=2 in the frame header → ERROR with err_code=2 on that byte. No frame_start.
- Bad sample counts:
  - fs=5121 → err_code=3.
  - file_total=20 with fs=40 → err_code=3.
  - Streaming (file_total=0) with two frames of fs=20 → two frame_end pulses and done stays 0.
- Reset mid-slice: apply rst_n=0 for one cycle after 3 slice bytes → all outputs are 0 and state_o=FILE_HDR. A fresh valid stream then decodes correctly.
